// File: rtl/softex_out_packer_pkg.sv
// softex_pkg: shared packer state type and default beat/word widths.
package softex_pkg;
    localparam int DEF_IN_DW     = 64;
    localparam int DEF_ACTUAL_DW = 256;
    typedef enum logic [1:0] {IDLE, PACK, DRAIN, DONE} packer_state_t;
endpackage

// File: rtl/softex_out_packer_if.sv
// hwpe_stream_intf_stream: valid/ready stream with byte strobes.
interface hwpe_stream_intf_stream #(
    parameter int DATA_WIDTH = 64
) ();
    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;
    modport source (output valid, data, strb, input ready);
    modport sink   (input valid, data, strb, output ready);
    modport master (output valid, data, strb, input ready);
    modport slave  (input valid, data, strb, output ready);
endinterface

// File: rtl/softex_out_packer_lane_sel.sv
// softex_out_packer_lane_sel: decodes a lane index into data and strobe write masks.
module softex_out_packer_lane_sel #(
    parameter int IN_DW     = 64,
    parameter int ACTUAL_DW = 256,
    parameter int LANE_W    = 2
) (
    input  logic [LANE_W-1:0]      lane,
    output logic [ACTUAL_DW-1:0]   data_mask,
    output logic [ACTUAL_DW/8-1:0] strb_mask
);
    for (genvar i = 0; i < ACTUAL_DW / IN_DW; i++) begin : g_lane
        assign data_mask[i*IN_DW +: IN_DW]         = {IN_DW{lane == LANE_W'(i)}};
        assign strb_mask[i*IN_DW/8 +: IN_DW/8]     = {(IN_DW/8){lane == LANE_W'(i)}};
    end
endmodule

// File: rtl/softex_out_packer.sv
// softex_out_packer: packs IN_DW result beats into strobed ACTUAL_DW store words,
// with a double-buffered assembly/output pair so one beat per cycle is sustained.
module softex_out_packer
    import softex_pkg::*;
#(
    parameter int IN_DW     = DEF_IN_DW,
    parameter int ACTUAL_DW = DEF_ACTUAL_DW,
    parameter int LEN_W     = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic                   enable_i,
    input  logic                   start_i,
    input  logic [LEN_W-1:0]       len_i,
    hwpe_stream_intf_stream.sink   stream_i,
    hwpe_stream_intf_stream.source stream_o,
    output logic                   busy_o,
    output logic                   done_o
);
    localparam int RATIO  = ACTUAL_DW / IN_DW;
    localparam int SW     = ACTUAL_DW / 8;
    localparam int LANE_W = RATIO > 1 ? $clog2(RATIO) : 1;

    packer_state_t state, state_nxt;
    logic [LEN_W-1:0] beat_cnt, beat_cnt_nxt, len_q;
    logic [ACTUAL_DW-1:0] asm_d, asm_d_nxt, out_d, out_d_nxt, base_d, cur_d, dmask;
    logic [SW-1:0] asm_s, asm_s_nxt, out_s, out_s_nxt, base_s, cur_s, smask;
    logic asm_pend, asm_pend_nxt, out_full, out_full_nxt;
    logic [LANE_W-1:0] lane;
    logic in_hs, out_hs, can_take, go, last, beat_done, move_pend, load_new;

    softex_out_packer_lane_sel #(.IN_DW(IN_DW), .ACTUAL_DW(ACTUAL_DW), .LANE_W(LANE_W)) lane_sel (
        .lane(lane), .data_mask(dmask), .strb_mask(smask)
    );

    assign in_hs     = stream_i.valid && stream_i.ready;
    assign out_hs    = out_full && stream_o.ready;
    assign can_take  = !out_full || out_hs;
    assign go        = state == IDLE && start_i;
    assign lane      = LANE_W'(beat_cnt % LEN_W'(RATIO));
    assign last      = beat_cnt == len_q - LEN_W'(1);
    assign beat_done = in_hs && (lane == LANE_W'(RATIO - 1) || last);
    assign move_pend = asm_pend && can_take;
    assign load_new  = !asm_pend && beat_done && can_take;

    assign stream_o.valid = out_full;
    assign stream_o.data  = out_d;
    assign stream_o.strb  = out_s;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clear_i) state_nxt = IDLE;
        else if (state == IDLE && start_i) state_nxt = len_i != '0 ? PACK : DONE;
        else if (state == PACK && in_hs && last) state_nxt = DRAIN;
        else if (state == DRAIN && !asm_pend && can_take) state_nxt = DONE;
        else if (state == DONE) state_nxt = IDLE;
    end

    always_comb begin
        busy_o         = state != IDLE;
        done_o         = state == DONE && !clear_i;
        stream_i.ready = state == PACK && enable_i && !(asm_pend && !can_take);
    end

    // A pending complete word always leaves first; a word completed behind it waits in assembly.
    always_comb begin
        base_d       = asm_pend ? '0 : asm_d;
        base_s       = asm_pend ? '0 : asm_s;
        cur_d        = in_hs ? base_d | ({RATIO{stream_i.data}} & dmask) : base_d;
        cur_s        = in_hs ? base_s | smask : base_s;
        asm_d_nxt    = clear_i || load_new ? '0 : (asm_pend && !can_take) ? asm_d : cur_d;
        asm_s_nxt    = clear_i || load_new ? '0 : (asm_pend && !can_take) ? asm_s : cur_s;
        asm_pend_nxt = !clear_i && (asm_pend ? (!can_take || beat_done) : (beat_done && !can_take));
        out_d_nxt    = clear_i ? '0 : move_pend ? asm_d : load_new ? cur_d : out_hs ? '0 : out_d;
        out_s_nxt    = clear_i ? '0 : move_pend ? asm_s : load_new ? cur_s : out_hs ? '0 : out_s;
        out_full_nxt = !clear_i && (move_pend || load_new || (out_full && !out_hs));
        beat_cnt_nxt = clear_i || go ? '0 : in_hs ? beat_cnt + LEN_W'(1) : beat_cnt;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            beat_cnt <= '0;
            len_q    <= '0;
            asm_d    <= '0;
            asm_s    <= '0;
            asm_pend <= 1'b0;
            out_d    <= '0;
            out_s    <= '0;
            out_full <= 1'b0;
        end else begin
            beat_cnt <= beat_cnt_nxt;
            len_q    <= go ? len_i : len_q;
            asm_d    <= asm_d_nxt;
            asm_s    <= asm_s_nxt;
            asm_pend <= asm_pend_nxt;
            out_d    <= out_d_nxt;
            out_s    <= out_s_nxt;
            out_full <= out_full_nxt;
        end
    end
endmodule

// File: tb/tb_softex_out_packer.sv
// tb_softex_out_packer: directed rows checked against a beat-to-word model of the packer.
module tb_softex_out_packer;
    localparam int IN_DW     = 64;
    localparam int ACTUAL_DW = 256;
    localparam int LEN_W     = 16;
    localparam int R         = ACTUAL_DW / IN_DW;
    localparam int SW        = ACTUAL_DW / 8;
    typedef logic [ACTUAL_DW-1:0] word_t;
    typedef logic [SW-1:0] strb_t;

    logic clk = 0, rst = 0, clear = 0, enable = 1, start = 0;
    logic [LEN_W-1:0] len = '0;
    logic busy, done;
    hwpe_stream_intf_stream #(.DATA_WIDTH(IN_DW)) s_in ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(ACTUAL_DW)) s_out ();

    int checks = 0, fails = 0, cyc = 0;
    int row_len = 0, in_cnt = 0, out_cnt = 0, vcnt = 0, stalls = 0, m_lane = 0;
    int start_cyc = 0, beat3_cyc = 0, first_v = -1, last_hs_cyc = 0, done_cyc = 0;
    bit done_due = 0, hold_v = 0;
    word_t acc_d = '0, hold_d = '0;
    strb_t acc_s = '0, hold_s = '0;
    word_t exp_d[$], got_d[$];
    strb_t exp_s[$], got_s[$];

    softex_out_packer #(.IN_DW(IN_DW), .ACTUAL_DW(ACTUAL_DW), .LEN_W(LEN_W)) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .enable_i(enable), .start_i(start),
        .len_i(len), .stream_i(s_in), .stream_o(s_out), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Model: every accepted beat lands in lane idx%R; a word closes at lane R-1 or the row's last beat.
    always @(negedge clk) begin
        cyc++;
        chkb("done_o", done, done_due);
        done_due = 0;
        if (done) done_cyc = cyc;
        if (rst || clear) begin
            exp_d.delete();
            exp_s.delete();
            in_cnt = 0;
            out_cnt = 0;
            acc_d = '0;
            acc_s = '0;
            hold_v = 0;
            row_len = 0;
        end else begin
            if (hold_v) begin
                chkb("valid_hold", s_out.valid, 1'b1);
                chk("data_hold", s_out.data, hold_d);
                chk("strb_hold", word_t'(s_out.strb), word_t'(hold_s));
            end
            if (start && !busy) begin
                row_len = int'(len);
                in_cnt = 0;
                out_cnt = 0;
                first_v = -1;
                start_cyc = cyc;
                done_due = row_len == 0;
            end
            if (s_out.valid) vcnt++;
            if (s_out.valid && first_v < 0) first_v = cyc;
            if (s_in.valid && s_in.ready) begin
                m_lane = in_cnt % R;
                if (in_cnt == 3) beat3_cyc = cyc;
                acc_d[m_lane*IN_DW +: IN_DW] = s_in.data;
                acc_s[m_lane*(IN_DW/8) +: IN_DW/8] = '1;
                if (m_lane == R - 1 || in_cnt == row_len - 1) begin
                    exp_d.push_back(acc_d);
                    exp_s.push_back(acc_s);
                    acc_d = '0;
                    acc_s = '0;
                end
                in_cnt++;
            end
            if (s_out.valid && s_out.ready) begin
                got_d.push_back(s_out.data);
                got_s.push_back(s_out.strb);
                last_hs_cyc = cyc;
                checks++;
                if (exp_d.size() == 0) begin
                    fails++;
                    $display("FAIL extra_word: got %0h expected no word", s_out.data);
                end else begin
                    chk("word_data", s_out.data, exp_d.pop_front());
                    chk("word_strb", word_t'(s_out.strb), word_t'(exp_s.pop_front()));
                end
                out_cnt++;
                if (out_cnt == (row_len + R - 1) / R) done_due = 1;
            end
            hold_v = s_out.valid && !s_out.ready;
            hold_d = s_out.data;
            hold_s = s_out.strb;
        end
    end

    task automatic do_start(input int n);
        @(posedge clk); #1;
        start = 1'b1;
        len = LEN_W'(n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input int n, input logic [IN_DW-1:0] base);
        int i = 0;
        int guard = 0;
        bit hs;
        s_in.valid = 1'b1;
        s_in.data = base;
        while (i < n && guard < 400) begin
            @(negedge clk);
            hs = s_in.ready;
            if (!hs) stalls++;
            @(posedge clk); #1;
            if (hs) begin
                i++;
                s_in.data = base + IN_DW'(i);
            end
            guard++;
        end
        s_in.valid = 1'b0;
        chki("send_beats", i, n);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chkb("done_seen", done, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic new_row();
        got_d.delete();
        got_s.delete();
        stalls = 0;
    endtask

    initial begin
        int vsave;
        s_in.valid = 1'b0;
        s_in.data = '0;
        s_in.strb = '1;
        s_out.ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        chkb("rst_in_ready", s_in.ready, 1'b0);
        chkb("rst_out_valid", s_out.valid, 1'b0);
        chk("rst_out_data", s_out.data, '0);
        chk("rst_out_strb", word_t'(s_out.strb), '0);
        chkb("rst_busy", busy, 1'b0);
        chkb("rst_done", done, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        new_row();
        do_start(8);
        send(8, 64'd0);
        wait_done(20);
        chki("r8_words", got_d.size(), 2);
        chk("r8_w0", got_d[0], {64'd3, 64'd2, 64'd1, 64'd0});
        chk("r8_w1", got_d[1], {64'd7, 64'd6, 64'd5, 64'd4});
        chk("r8_strb", word_t'(got_s[0] & got_s[1]), word_t'(32'hFFFF_FFFF));
        chki("r8_stalls", stalls, 0);
        chki("r8_valid_lat", first_v - beat3_cyc, 1);
        chki("r8_done_lat", done_cyc - last_hs_cyc, 1);
        chki("r8_left", exp_d.size(), 0);

        new_row();
        do_start(5);
        fork
            send(5, 64'h10);
            begin
                repeat (2) @(posedge clk);
                #1 enable = 1'b0;
                @(negedge clk);
                chkb("en_low_ready", s_in.ready, 1'b0);
                repeat (2) @(posedge clk);
                #1 enable = 1'b1;
            end
        join
        wait_done(20);
        chki("r5_words", got_d.size(), 2);
        chk("r5_w0", got_d[0], {64'h13, 64'h12, 64'h11, 64'h10});
        chk("r5_w1", got_d[1], {192'd0, 64'h14});
        chk("r5_s1", word_t'(got_s[1]), word_t'(32'h0000_00FF));

        new_row();
        s_out.ready = 1'b0;
        do_start(12);
        fork
            send(12, 64'h20);
            begin
                repeat (10) @(posedge clk);
                #1;
                chki("bp_beats", in_cnt, 8);
                chkb("bp_ready", s_in.ready, 1'b0);
                s_out.ready = 1'b1;
            end
        join
        wait_done(30);
        chki("bp_words", got_d.size(), 3);
        chk("bp_w0", got_d[0], {64'h23, 64'h22, 64'h21, 64'h20});
        chk("bp_w2", got_d[2], {64'h2B, 64'h2A, 64'h29, 64'h28});
        chki("bp_left", exp_d.size(), 0);

        new_row();
        vsave = vcnt;
        do_start(0);
        wait_done(5);
        chki("len0_done_lat", done_cyc - start_cyc, 1);
        chki("len0_no_valid", vcnt - vsave, 0);
        chki("len0_words", got_d.size(), 0);

        do_start(4);
        send(3, 64'h55);
        @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        chkb("clr_busy", busy, 1'b0);
        chkb("clr_valid", s_out.valid, 1'b0);
        chkb("clr_ready", s_in.ready, 1'b0);
        new_row();
        do_start(4);
        send(4, 64'hA);
        wait_done(20);
        chki("clr_words", got_d.size(), 1);
        chk("clr_w0", got_d[0], {64'hD, 64'hC, 64'hB, 64'hA});
        chk("clr_s0", word_t'(got_s[0]), word_t'(32'hFFFF_FFFF));

        new_row();
        s_out.ready = 1'b0;
        do_start(8);
        send(4, 64'h70);
        #2;
        chkb("pre_rst_valid", s_out.valid, 1'b1);
        chkb("pre_rst_busy", busy, 1'b1);
        chkb("pre_rst_ready", s_in.ready, 1'b1);
        rst = 1'b1;
        #1;
        chkb("arst_valid", s_out.valid, 1'b0);
        chkb("arst_busy", busy, 1'b0);
        chkb("arst_ready", s_in.ready, 1'b0);
        chk("arst_data", s_out.data, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        s_out.ready = 1'b1;
        new_row();
        do_start(4);
        send(4, 64'hB0);
        wait_done(20);
        chki("post_rst_words", got_d.size(), 1);
        chk("post_rst_w0", got_d[0], {64'hB3, 64'hB2, 64'hB1, 64'hB0});

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
